vscpu_ram_responder: RTL and testbench

//  Memory-side responder for the VSCPU RAM port. Owns the word-addressed RAM and serves

---
 rtl/vscpu_ram_responder.sv | 78 +++++++
 tb/tb_vscpu_ram_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vscpu_ram_responder.sv
// vscpu_ram_responder: VSCPU RAM owner that clears memory and loads a program while
// holding the CPU in reset, then serves CPU reads and writes and counts writes.
module vscpu_ram_responder #(
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 16384,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] addr_toRAM,
    input  logic [DATA_W-1:0] data_toRAM,
    output logic [DATA_W-1:0] data_fromRAM,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              cpu_hold,
    output logic [31:0]       wr_count,
    output logic              err_oor
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;
    state_t state;
    logic [AW-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic cpu_ok, ld_ok, ld_fire, we;
    logic [AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    assign ld_ready = state == LOAD;
    assign cpu_hold = state != RUN;
    assign cpu_ok   = {1'b0, addr_toRAM} < DEPTH_X;
    assign ld_ok    = {1'b0, ld_addr} < DEPTH_X;
    assign ld_fire  = ld_valid && ld_ready;
    // One RAM write port, owned by CLEAR, LOAD or the CPU depending on the phase
    always_comb begin
        we    = !rst && ((state == CLEAR) || (ld_fire && ld_ok) || (state == RUN && wrEn && cpu_ok));
        waddr = state == CLEAR ? clr_ptr : state == LOAD ? ld_addr[AW-1:0] : addr_toRAM[AW-1:0];
        wdata = state == CLEAR ? '0 : state == LOAD ? ld_data : data_toRAM;
    end
    // RAM array itself is never reset; only the CLEAR phase zeroes it
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // Registered read returning the pre-write word; zero outside RUN or out of range
    always_ff @(posedge clk) begin
        data_fromRAM <= (!rst && state == RUN && cpu_ok) ? mem[addr_toRAM[AW-1:0]] : '0;
    end
    // Phase sequencing CLEAR -> LOAD -> RUN plus error and write tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR_ON_RST ? CLEAR : LOAD;
            clr_ptr  <= '0;
            wr_count <= '0;
            err_oor  <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == LAST) state <= LOAD;
                end
                LOAD: begin
                    if (ld_fire && !ld_ok) err_oor <= 1'b1;
                    if (ld_fire && ld_last) state <= RUN;
                end
                RUN: begin
                    if (!cpu_ok) err_oor <= 1'b1;
                    if (wrEn && cpu_ok && wr_count != '1) wr_count <= wr_count + 32'd1;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_vscpu_ram_responder.sv
// tb_vscpu_ram_responder: scoreboard bench for two responders (with and without CLEAR)
module tb_vscpu_ram_responder;
    localparam int F_DATA = 0, F_HOLD = 1, F_RDY = 2, F_WC = 3, F_ERR = 4;
    typedef struct {
        int          cyc;
        int          d;
        int          f;
        logic [31:0] exp;
        string       name;
    } exp_t;
    logic clk = 1'b0;
    logic rst [2];
    logic wr [2];
    logic [13:0] addr [2];
    logic [31:0] din [2];
    logic [31:0] dout [2];
    logic ldv [2];
    logic ldr [2];
    logic [13:0] lda [2];
    logic [31:0] ldd [2];
    logic ldl [2];
    logic hold [2];
    logic [31:0] wc [2];
    logic err [2];
    logic [31:0] gm [2][16];
    exp_t sb [$];
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] prog [16] = '{32'h0002_C00C, 32'h0002_800D, 32'hC002_400A, 32'hC002_0007,
                               32'hA001_800E, 32'hC003_C007, 32'h0, 32'h0,
                               32'h0, 32'h4, 32'h3, 32'h0,
                               32'h5, 32'hFFFF_FFFF, 32'hC, 32'h5};
    logic [31:0] fin [16] = '{32'h0002_C00C, 32'h0002_800D, 32'hC002_400A, 32'hC002_0007,
                              32'hA001_800E, 32'hC003_C007, 32'h5, 32'h0,
                              32'h0, 32'h4, 32'h0, 32'hF,
                              32'h5, 32'hFFFF_FFFF, 32'hC, 32'h5};

    for (genvar i = 0; i < 2; i++) begin : g_dut
        vscpu_ram_responder #(.ADDR_W(14), .DATA_W(32), .DEPTH(16), .CLEAR_ON_RST(i == 0)) dut (
            .clk(clk), .rst(rst[i]), .wrEn(wr[i]), .addr_toRAM(addr[i]), .data_toRAM(din[i]),
            .data_fromRAM(dout[i]), .ld_valid(ldv[i]), .ld_ready(ldr[i]), .ld_addr(lda[i]),
            .ld_data(ldd[i]), .ld_last(ldl[i]), .cpu_hold(hold[i]), .wr_count(wc[i]), .err_oor(err[i])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int d, int f);
        return f == F_DATA ? dout[d] : f == F_HOLD ? 32'(hold[d]) : f == F_RDY ? 32'(ldr[d]) :
               f == F_WC ? wc[d] : 32'(err[d]);
    endfunction

    // Monitor: compare every scoreboard entry due on this cycle against the outputs
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [31:0] act;
                act = actual(sb[i].d, sb[i].f);
                n_chk++;
                if (act === sb[i].exp) n_pass++;
                else $display("FAIL %s: dut%0d got %h expected %h", sb[i].name, sb[i].d, act, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic expect_at(int d, int f, logic [31:0] v, int k, string nm);
        sb.push_back('{cyc + k, d, f, v, nm});
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic beat(int d, logic [13:0] a, logic [31:0] v, logic last);
        ldv[d] = 1'b1; lda[d] = a; ldd[d] = v; ldl[d] = last;
        if (a < 16) gm[d][a[3:0]] = v;
        tick();
        ldv[d] = 1'b0; ldl[d] = 1'b0;
    endtask

    task automatic rd_chk(int d, logic [13:0] a, string nm);
        addr[d] = a; wr[d] = 1'b0;
        expect_at(d, F_DATA, a < 16 ? gm[d][a[3:0]] : 32'h0, 1, nm);
        tick();
    endtask

    task automatic bus_rd(int d, logic [13:0] a, output logic [31:0] v);
        addr[d] = a; wr[d] = 1'b0;
        tick();
        v = dout[d];
    endtask

    task automatic bus_wr(int d, logic [13:0] a, logic [31:0] v);
        addr[d] = a; din[d] = v; wr[d] = 1'b1;
        if (a < 16) gm[d][a[3:0]] = v;
        tick();
        wr[d] = 1'b0;
    endtask

    task automatic clear_model(int d);
        for (int i = 0; i < 16; i++) gm[d][i] = 32'h0;
    endtask

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus: directed sequences on dut0 (CLEAR) and dut1 (no CLEAR)
    initial begin
        logic [31:0] ins, x, y;
        logic [13:0] pc, npc;
        logic halted;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; wr[d] = 1'b0; addr[d] = '0; din[d] = '0;
            ldv[d] = 1'b0; lda[d] = '0; ldd[d] = '0; ldl[d] = 1'b0;
        end
        tick();
        expect_at(0, F_HOLD, 1, 1, "rst_hold");
        expect_at(0, F_RDY, 0, 1, "rst_rdy");
        expect_at(0, F_WC, 0, 1, "rst_wc");
        expect_at(0, F_ERR, 0, 1, "rst_err");
        expect_at(0, F_DATA, 0, 1, "rst_data");
        tick();
        rst[0] = 1'b0;
        expect_at(0, F_RDY, 0, 1, "clr_rdy_first");
        expect_at(0, F_RDY, 0, 15, "clr_rdy_last");
        expect_at(0, F_HOLD, 1, 15, "clr_hold");
        expect_at(0, F_RDY, 1, 16, "clr_done");
        tick(16);
        clear_model(0);
        beat(0, 14'd0, 32'h9000_4005, 1'b0);
        expect_at(0, F_RDY, 1, 1, "ld_rdy_idle");
        tick();
        expect_at(0, F_HOLD, 0, 1, "run_hold");
        expect_at(0, F_RDY, 0, 1, "run_rdy");
        expect_at(0, F_ERR, 0, 1, "run_err_clean");
        beat(0, 14'd5, 32'h0000_0007, 1'b1);
        rd_chk(0, 14'd0, "first_fetch");
        rd_chk(0, 14'd5, "rd_addr5");
        for (int i = 0; i < 16; i++) rd_chk(0, 14'(i), "image");
        ldv[0] = 1'b1; lda[0] = 14'd2; ldd[0] = 32'hFFFF_FFFF;
        expect_at(0, F_RDY, 0, 1, "run_ld_ignored");
        tick();
        ldv[0] = 1'b0;
        rd_chk(0, 14'd2, "run_ld_nowrite");
        addr[0] = 14'd3; din[0] = 32'hDEAD_BEEF; wr[0] = 1'b1;
        expect_at(0, F_DATA, 32'h0, 1, "rbw_old");
        tick();
        gm[0][3] = 32'hDEAD_BEEF; wr[0] = 1'b0;
        expect_at(0, F_DATA, 32'hDEAD_BEEF, 1, "rbw_new");
        expect_at(0, F_WC, 1, 1, "wc_one");
        tick();
        addr[0] = 14'd17; din[0] = 32'h55; wr[0] = 1'b1;
        expect_at(0, F_ERR, 1, 1, "oor_err");
        expect_at(0, F_WC, 1, 1, "oor_wc_hold");
        expect_at(0, F_DATA, 0, 1, "oor_wr_rd");
        tick();
        wr[0] = 1'b0;
        rd_chk(0, 14'd17, "oor_rd");
        expect_at(0, F_ERR, 1, 1, "err_sticky");
        rd_chk(0, 14'd1, "no_alias");
        rst[1] = 1'b0;
        expect_at(1, F_RDY, 1, 1, "b_load");
        expect_at(1, F_HOLD, 1, 1, "b_hold");
        tick();
        expect_at(1, F_HOLD, 0, 1, "b_run");
        beat(1, 14'd0, 32'h1, 1'b1);
        bus_wr(1, 14'd3, 32'hDEAD_BEEF);
        rd_chk(1, 14'd3, "b_rd3");
        addr[1] = 14'd30;
        expect_at(1, F_ERR, 1, 1, "b_rdonly_err");
        expect_at(1, F_WC, 1, 1, "b_wc");
        tick();
        rst[1] = 1'b1; addr[1] = 14'd0;
        expect_at(1, F_HOLD, 1, 1, "b_rst_hold");
        expect_at(1, F_WC, 0, 1, "b_rst_wc");
        expect_at(1, F_ERR, 0, 1, "b_rst_err");
        expect_at(1, F_RDY, 1, 1, "b_rst_load");
        expect_at(1, F_DATA, 0, 1, "b_rst_data");
        tick();
        rst[1] = 1'b0;
        expect_at(1, F_ERR, 1, 1, "b_ld_oor");
        beat(1, 14'd20, 32'h1234, 1'b0);
        expect_at(1, F_HOLD, 0, 1, "b_rerun");
        beat(1, 14'd0, 32'h0, 1'b1);
        rd_chk(1, 14'd3, "b_mem_kept");
        rst[0] = 1'b1;
        expect_at(0, F_WC, 0, 1, "p_rst_wc");
        expect_at(0, F_ERR, 0, 1, "p_rst_err");
        tick();
        rst[0] = 1'b0;
        tick(16);
        clear_model(0);
        for (int i = 0; i < 16; i++) beat(0, 14'(i), prog[i], i == 15);
        pc = '0;
        halted = 1'b0;
        for (int s = 0; s < 200 && !halted; s++) begin
            bus_rd(0, pc, ins);
            npc = pc + 14'd1;
            case (ins[31:29])
                3'd0: begin
                    bus_rd(0, ins[27:14], x);
                    bus_rd(0, ins[13:0], y);
                    bus_wr(0, ins[27:14], x + y);
                end
                3'd5: begin
                    bus_rd(0, ins[13:0], y);
                    bus_rd(0, y[13:0], x);
                    bus_wr(0, ins[27:14], x);
                end
                3'd6: begin
                    bus_rd(0, ins[13:0], y);
                    if (y == 0) begin
                        bus_rd(0, ins[27:14], x);
                        npc = x[13:0];
                    end
                end
                default: ;
            endcase
            halted = npc == pc;
            pc = npc;
        end
        n_chk++;
        if (halted) n_pass++;
        else $display("FAIL prog_halt: program still running at pc %0d, required halt at 5", pc);
        expect_at(0, F_WC, 7, 1, "prog_wc");
        for (int i = 0; i < 16; i++) begin
            addr[0] = 14'(i);
            expect_at(0, F_DATA, fin[i], 1, "prog_image");
            tick();
        end
        tick(3);
        foreach (sb[i]) begin
            n_chk++;
            $display("FAIL %s: dut%0d never sampled, expected %h", sb[i].name, sb[i].d, sb[i].exp);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
